scale_seq_ctrl: RTL

Sequencing controller that scales a signed operand by 2^k. It applies the team's single-step ×2 / ÷2 operation k times under a finite-state machine with valid/ready handshakes on both the command and result sides. Multiply steps saturate and flag overflow. It sits between the ALU command decoder and the result bus, so shift-scale commands share one iterative step unit instead of a barrel shifter.

---
 rtl/scale_pkg.sv | 25 ++
 rtl/scale_step.sv | 41 ++++
 rtl/scale_seq_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the shift-scale sequencing controller.
package scale_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step direction encoding
   localparam logic DIR_DIV = 1'b0;
   localparam logic DIR_MUL = 1'b1;

   // Largest value representable by an N+2 bit signed accumulator
   function automatic int sat_max(input int n);
      return (1 << (n + 1)) - 1;
   endfunction

   // Smallest value representable by an N+2 bit signed accumulator
   function automatic int sat_min(input int n);
      return -(1 << (n + 1));
   endfunction

endpackage

// File: rtl/scale_step.sv
// Single-step x2 / /2 unit on an N+2 bit signed accumulator.
// Multiply saturates to the accumulator range; divide truncates toward zero.
module scale_step
   import scale_pkg::*;
#(
   parameter int N = 4
) (
   input  logic signed [N+1:0] acc,
   input  logic                dir,
   output logic signed [N+1:0] acc_next,
   output logic                sat
);

   localparam int W = N + 2;
   localparam logic signed [W-1:0] MAX_V = W'(sat_max(N));
   localparam logic signed [W-1:0] MIN_V = W'(sat_min(N));

   logic signed [W:0]   dbl;
   logic signed [W-1:0] half_in;

   // Compute one step; doubling overflows when the top two bits of the
   // widened product disagree, and biasing negatives by +1 before the
   // arithmetic shift turns floor division into truncation toward zero.
   always_comb begin
      dbl      = {acc, 1'b0};
      half_in  = acc + {{(W-1){1'b0}}, acc[W-1]};
      acc_next = acc;
      sat      = 1'b0;
      if (dir == DIR_MUL) begin
         if (dbl[W] != dbl[W-1]) begin
            sat      = 1'b1;
            acc_next = dbl[W] ? MIN_V : MAX_V;
         end else begin
            acc_next = dbl[W-1:0];
         end
      end else begin
         acc_next = half_in >>> 1;
      end
   end

endmodule

// File: rtl/scale_seq_ctrl.sv
// Iterative scale-by-2^k controller with valid/ready command and result ports.
module scale_seq_ctrl
   import scale_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic signed [N-1:0] op_a,
   input  logic                op_dir,
   input  logic [CW-1:0]       op_cnt,
   output logic                res_valid,
   input  logic                res_ready,
   output logic signed [N+1:0] res_data,
   output logic                res_ovf,
   output logic                busy
);

   state_t              state;
   state_t              state_next;
   logic signed [N+1:0] acc;
   logic signed [N+1:0] step_out;
   logic                step_sat;
   logic [CW-1:0]       rem;
   logic                ovf;
   logic                dir;

   scale_step #(.N(N)) u_step (
      .acc      (acc),
      .dir      (dir),
      .acc_next (step_out),
      .sat      (step_sat)
   );

   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign res_valid   = (state == DONE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_valid) state_next = (op_cnt != '0) ? RUN : DONE;
         RUN:  if (rem == CW'(1)) state_next = DONE;
         DONE: if (res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Accumulator, step counter, sticky flag and registered result.
   // The result register is loaded on the edge that enters DONE and cleared
   // on the result handshake, so it reads zero whenever no result is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         rem      <= '0;
         ovf      <= 1'b0;
         dir      <= DIR_DIV;
         res_data <= '0;
         res_ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  acc <= {{2{op_a[N-1]}}, op_a};
                  dir <= op_dir;
                  rem <= op_cnt;
                  ovf <= 1'b0;
                  if (op_cnt == '0) begin
                     res_data <= {{2{op_a[N-1]}}, op_a};
                     res_ovf  <= 1'b0;
                  end
               end
            end
            RUN: begin
               acc <= step_out;
               rem <= rem - CW'(1);
               ovf <= ovf | step_sat;
               if (rem == CW'(1)) begin
                  res_data <= step_out;
                  res_ovf  <= ovf | step_sat;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_data <= '0;
                  res_ovf  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
